cpu_iack_sequencer: RTL and testbench

CPU_IACK_SEQUENCER -- requirements
Module: cpu_iack_sequencer

---
 rtl/cpu_iack_sequencer.sv | 143 ++++++++++++++
 tb/tb_cpu_iack_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_iack_sequencer.sv
// 68000 interrupt-acknowledge sequencer: autovectors valid IACK cycles, bus-errors spurious ones.
// Optional build macro IPL_GLITCH_FILTER_EN adds a 2-tick stability filter on the IPL path.
module cpu_iack_sequencer #(
    parameter int VPA_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic [2:0] _ipl_in,
    output logic [2:0] _ipl_out,
    input  logic [2:0] cpu_fc,
    input  logic [3:0] cpu_a_hi,
    input  logic [2:0] cpu_a_lo,
    input  logic       _cpu_as,
    output logic       _vpa,
    output logic       _berr,
    output logic       iack_strobe,
    output logic [2:0] iack_level
);

    localparam logic [3:0] DELAY_LAST = 4'(VPA_DELAY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        DELAY   = 3'd2,
        VPA     = 3'd3,
        BERR    = 3'd4,
        WAIT_AS = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic [2:0] r_lvl;
    logic [2:0] r_ipl_out;
    logic [2:0] r_iack_level;
    logic       r_vpa_n;
    logic       r_berr_n;
    logic       r_strobe;
    logic       w_strobe;
    logic       w_iack;
    logic [2:0] w_pend;

    assign w_iack = !_cpu_as && (cpu_fc == 3'b111) && (cpu_a_hi == 4'hF);
    assign w_pend = ~r_ipl_out;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_strobe   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_iack) w_next = DECODE;
            end
            DECODE: begin
                w_cnt_next = 4'd0;
                if (_cpu_as) begin
                    w_next = IDLE;
                end else if ((r_lvl != 3'd0) && (r_lvl <= w_pend)) begin
                    w_next   = DELAY;
                    w_strobe = 1'b1;
                end else begin
                    w_next = BERR;
                end
            end
            DELAY: begin
                // The counter reaches VPA_DELAY after VPA_DELAY ticks; the next tick enters VPA.
                if (_cpu_as) begin
                    w_next = IDLE;
                end else if (r_cnt == DELAY_LAST) begin
                    w_next = VPA;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            VPA, BERR: begin
                if (_cpu_as) w_next = WAIT_AS;
            end
            WAIT_AS: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same tick as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_lvl        <= 3'd0;
            r_vpa_n      <= 1'b1;
            r_berr_n     <= 1'b1;
            r_strobe     <= 1'b0;
            r_iack_level <= 3'd0;
        end else if (clk7_en) begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_vpa_n  <= (w_next != VPA);
            r_berr_n <= (w_next != BERR);
            r_strobe <= w_strobe;
            if ((r_state == IDLE) && w_iack) r_lvl <= cpu_a_lo;
            if (w_strobe) r_iack_level <= r_lvl;
        end
    end

`ifdef IPL_GLITCH_FILTER_EN
    logic [2:0] r_flt0;
    logic [2:0] r_flt1;

    // The whole filter pipeline freezes outside IDLE, so it refills after every acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flt0    <= 3'b111;
            r_flt1    <= 3'b111;
            r_ipl_out <= 3'b111;
        end else if (clk7_en && (r_state == IDLE)) begin
            r_flt0 <= _ipl_in;
            r_flt1 <= r_flt0;
            if (r_flt0 == r_flt1) r_ipl_out <= r_flt0;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ipl_out <= 3'b111;
        end else if (clk7_en && (r_state == IDLE)) begin
            r_ipl_out <= _ipl_in;
        end
    end
`endif

    assign _ipl_out    = r_ipl_out;
    assign _vpa        = r_vpa_n;
    assign _berr       = r_berr_n;
    assign iack_strobe = r_strobe;
    assign iack_level  = r_iack_level;

endmodule

// File: tb/tb_cpu_iack_sequencer.sv
// Self-checking bench for cpu_iack_sequencer: accepted strobe levels go through a scoreboard queue.
module tb_cpu_iack_sequencer;

    localparam int VPA_DELAY = 2;
`ifdef IPL_GLITCH_FILTER_EN
    localparam int IPL_LAT        = 3;
    localparam int GLITCH_VISIBLE = 0;
`else
    localparam int IPL_LAT        = 1;
    localparam int GLITCH_VISIBLE = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       clk7_en = 1'b0;
    logic [2:0] _ipl_in;
    logic [2:0] _ipl_out;
    logic [2:0] cpu_fc;
    logic [3:0] cpu_a_hi;
    logic [2:0] cpu_a_lo;
    logic       _cpu_as;
    logic       _vpa;
    logic       _berr;
    logic       iack_strobe;
    logic [2:0] iack_level;

    int         en_mode = 1;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [2:0] q_lvl[$];

    cpu_iack_sequencer #(.VPA_DELAY(VPA_DELAY)) dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en),
        ._ipl_in(_ipl_in), ._ipl_out(_ipl_out),
        .cpu_fc(cpu_fc), .cpu_a_hi(cpu_a_hi), .cpu_a_lo(cpu_a_lo), ._cpu_as(_cpu_as),
        ._vpa(_vpa), ._berr(_berr), .iack_strobe(iack_strobe), .iack_level(iack_level)
    );

    always #5 clk = ~clk;

    // Clock enable: 0 = every cycle, 1 = every other cycle, 2 = stalled.
    initial begin
        forever begin
            @(negedge clk);
            case (en_mode)
                0:       clk7_en = 1'b1;
                1:       clk7_en = ~clk7_en;
                default: clk7_en = 1'b0;
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit got;
        int guard;
        got = 1'b0;
        guard = 0;
        while (!got && guard < 200) begin
            @(posedge clk);
            got = clk7_en;
            guard++;
        end
        #1;
    endtask

    task automatic bus_idle();
        _cpu_as  = 1'b1;
        cpu_fc   = 3'b101;
        cpu_a_hi = 4'h0;
        cpu_a_lo = 3'd0;
    endtask

    task automatic drive_iack(input logic [2:0] lvl);
        cpu_fc   = 3'b111;
        cpu_a_hi = 4'hF;
        cpu_a_lo = lvl;
        _cpu_as  = 1'b0;
    endtask

    task automatic settle_ipl(input logic [2:0] ipl);
        _ipl_in = ipl;
        repeat (6) tick();
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected accepted level.
    always begin
        tick();
        if (iack_strobe) begin
            check_val("strobe_expected", q_lvl.size() != 0, 1);
            if (q_lvl.size() != 0) check_val("iack_level_at_strobe", iack_level, q_lvl.pop_front());
        end
        check_val("vpa_berr_exclusive", _vpa | _berr, 1);
    end

    task automatic iack_run(input string tag, input logic [2:0] ipl, input logic [2:0] lvl);
        bit         accept;
        int         n;
        logic [2:0] pend;
        settle_ipl(ipl);
        pend   = ~ipl;
        accept = (lvl != 3'd0) && (lvl <= pend);
        if (accept) q_lvl.push_back(lvl);
        drive_iack(lvl);
        tick();
        n = 0;
        while (_vpa && _berr && n < 40) begin
            tick();
            n++;
        end
        if (accept) begin
            check_val({tag, "_vpa_latency"}, n, VPA_DELAY + 2);
            check_val({tag, "_berr_idle"}, _berr, 1);
        end else begin
            check_val({tag, "_berr_latency"}, n, 1);
            check_val({tag, "_vpa_idle"}, _vpa, 1);
        end
        repeat (3) tick();
        check_val({tag, "_hold"}, accept ? _vpa : _berr, 0);
        _cpu_as = 1'b1;
        tick();
        check_val({tag, "_release"}, {_vpa, _berr}, 2'b11);
        bus_idle();
        tick();
        tick();
        check_val({tag, "_queue_drained"}, q_lvl.size(), 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        reset = 1'b1;
        _ipl_in = 3'b010;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ipl_out", _ipl_out, 3'b111);
        check_val("rst_vpa", _vpa, 1);
        check_val("rst_berr", _berr, 1);
        check_val("rst_strobe", iack_strobe, 0);
        check_val("rst_level", iack_level, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        iack_run("lvl3", 3'b100, 3'd3);
        check_val("lvl3_level_kept", iack_level, 3);
        iack_run("spurious", 3'b110, 3'd5);
        check_val("spurious_level_unchanged", iack_level, 3);
        en_mode = 0;
        iack_run("lvl4_pend7", 3'b000, 3'd4);
        iack_run("lvl0", 3'b000, 3'd0);
        iack_run("lvl7", 3'b000, 3'd7);
        en_mode = 1;

        // Abort during DELAY.
        settle_ipl(3'b101);
        q_lvl.push_back(3'd2);
        seen = 1'b0;
        drive_iack(3'd2);
        tick();
        tick();
        _cpu_as = 1'b1;
        tick();
        bus_idle();
        repeat (8) begin
            if (!_vpa) seen = 1'b1;
            tick();
        end
        check_val("abort_vpa_never_low", seen, 0);
        check_val("abort_one_strobe", q_lvl.size(), 0);
        check_val("abort_level", iack_level, 2);

        // IPL freeze during VPA.
        settle_ipl(3'b101);
        q_lvl.push_back(3'd2);
        drive_iack(3'd2);
        n = 0;
        while (_vpa && n < 40) begin
            tick();
            n++;
        end
        check_val("freeze_vpa_reached", _vpa, 0);
        _ipl_in = 3'b001;
        repeat (3) tick();
        check_val("freeze_in_vpa", _ipl_out, 3'b101);
        _cpu_as = 1'b1;
        tick();
        check_val("freeze_in_wait_as", _ipl_out, 3'b101);
        bus_idle();
        tick();
        check_val("freeze_first_idle", _ipl_out, 3'b101);
        n = 0;
        while (_ipl_out != 3'b001 && n < 10) begin
            tick();
            n++;
        end
        check_val("freeze_resume_latency", n, IPL_LAT);

        // One-tick glitch on IPL.
        settle_ipl(3'b111);
        _ipl_in = 3'b000;
        tick();
        _ipl_in = 3'b111;
        seen = 1'b0;
        repeat (5) begin
            if (_ipl_out == 3'b000) seen = 1'b1;
            tick();
        end
        check_val("glitch_visible", seen, GLITCH_VISIBLE);
        check_val("glitch_final", _ipl_out, 3'b111);

        // Non-IACK bus cycles.
        settle_ipl(3'b011);
        cpu_fc = 3'b110; cpu_a_hi = 4'hF; cpu_a_lo = 3'd4; _cpu_as = 1'b0;
        repeat (4) tick();
        check_val("non_iack_fc", {_vpa, _berr, iack_strobe}, 3'b110);
        cpu_fc = 3'b111; cpu_a_hi = 4'hE;
        repeat (4) tick();
        check_val("non_iack_ahi", {_vpa, _berr, iack_strobe}, 3'b110);
        check_val("non_iack_ipl", _ipl_out, 3'b011);
        bus_idle();
        tick();

        // Clock enable held low: nothing moves.
        en_mode = 2;
        @(negedge clk);
        #1;
        _ipl_in = 3'b010;
        repeat (6) @(posedge clk);
        #1;
        check_val("stall_ipl_held", _ipl_out, 3'b011);
        en_mode = 1;
        n = 0;
        while (_ipl_out != 3'b010 && n < 10) begin
            tick();
            n++;
        end
        check_val("stall_resume_latency", n, IPL_LAT);

        // Async reset while _vpa is low.
        settle_ipl(3'b000);
        q_lvl.push_back(3'd6);
        drive_iack(3'd6);
        n = 0;
        while (_vpa && n < 40) begin
            tick();
            n++;
        end
        check_val("mid_reset_vpa_reached", _vpa, 0);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_reset_vpa", _vpa, 1);
        check_val("mid_reset_berr", _berr, 1);
        check_val("mid_reset_strobe", iack_strobe, 0);
        check_val("mid_reset_level", iack_level, 0);
        check_val("mid_reset_ipl", _ipl_out, 3'b111);
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (!_vpa) seen = 1'b1;
        end
        check_val("post_reset_vpa_quiet", seen, 0);
        iack_run("post_reset", 3'b000, 3'd6);
        check_val("post_reset_level", iack_level, 6);

        check_val("final_queue_empty", q_lvl.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
